rf_wport_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two writers:
  - the in-order pipeline writeback stage (primary, never back-pressured);
  - a long-latency result source such as a mul/div or load unit (secondary, valid/ready).
- Buffers secondary results in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding long-latency destinations and reports read/write hazards to the hazard unit.
- Provides starvation protection by requesting a pipeline writeback stall.

---
 rtl/rf_wport_arbiter.sv | 148 ++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a busy scoreboard and starvation stall. Optional same-cycle bypass: RF_WPORT_BYPASS_EN.
module rf_wport_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  chk_a1,
  input  logic [4:0]  chk_a2,
  input  logic [4:0]  chk_rd,
  output logic        hz1,
  output logic        hz2,
  output logic        hzd,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW1 = AW + 1;
  localparam int CW  = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  state_t state;

  logic [4:0]     mem_rd   [DEPTH];
  logic [31:0]    mem_data [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW1-1:0] count, count_next;
  logic [CW-1:0]  cnt;
  logic [31:0]    busy, set_mask, clr_mask;

  logic empty, full, in_force, prim_ok, lu_xfer;
  logic head_grant, prim_grant, byp, push, pop, iss_fire;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign empty     = (count == '0);
  assign full      = (count == CW1'(DEPTH));
  assign in_force  = (state == FORCE);
  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Handshakes: a transfer happens on a cycle where valid and ready are both high at posedge;
  // ready never depends on valid, and both readies are held low while reset is asserted.
  assign lu_ready  = !reset && !full;
  assign iss_ready = !reset && (!busy[iss_rd] || (iss_rd == 5'd0));
  assign lu_xfer   = lu_valid && lu_ready;
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);

  assign prim_ok    = wb_we && (wb_rd != 5'd0);
  assign prim_grant = !in_force && prim_ok;
  assign head_grant = !empty && (in_force || !prim_ok);

`ifdef RF_WPORT_BYPASS_EN
  assign byp = lu_xfer && (lu_rd != 5'd0) && empty && !in_force && !prim_ok;
`else
  assign byp = 1'b0;
`endif

  assign push       = lu_xfer && (lu_rd != 5'd0) && !byp;
  assign pop        = !reset && head_grant;
  assign count_next = count + CW1'(push) - CW1'(pop);

  assign rf_we = !reset && (prim_grant || head_grant || byp);

  always_comb begin
    rf_a3 = 5'd0;
    rf_wd = 32'd0;
    if (head_grant) begin
      rf_a3 = head_rd;
      rf_wd = head_data;
    end else if (prim_grant) begin
      rf_a3 = wb_rd;
      rf_wd = wb_data;
    end else if (byp) begin
      rf_a3 = lu_rd;
      rf_wd = lu_data;
    end
  end

  // Clear is applied before set so an issue to a register never lost to a stray commit.
  assign set_mask = iss_fire ? (32'd1 << iss_rd) : 32'd0;
  assign clr_mask = (pop ? (32'd1 << head_rd) : 32'd0) | (byp ? (32'd1 << lu_rd) : 32'd0);

  assign hz1 = busy[chk_a1] && (chk_a1 != 5'd0);
  assign hz2 = busy[chk_a2] && (chk_a2 != 5'd0);
  assign hzd = busy[chk_rd] && (chk_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      busy      <= '0;
      state     <= IDLE;
      cnt       <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) begin
        mem_rd[wr_ptr]   <= lu_rd;
        mem_data[wr_ptr] <= lu_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      busy  <= (busy & ~clr_mask) | set_mask;
      // WAIT is entered together with the first entry, so cnt counts cycles the head is visible.
      case (state)
        IDLE: begin
          cnt       <= '0;
          stall_req <= 1'b0;
          if (count_next != '0) state <= WAIT;
        end
        WAIT: begin
          if (head_grant) begin
            cnt   <= '0;
            state <= (count_next != '0) ? WAIT : IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= FORCE;
            stall_req <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FORCE: begin
          cnt       <= '0;
          stall_req <= 1'b0;
          state     <= (count_next != '0) ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized + directed bench for rf_wport_arbiter against a queue/array reference model.
module tb_rf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_MAX = 4;
`ifdef RF_WPORT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic wb_we, lu_valid, iss_valid;
  logic [4:0] wb_rd, lu_rd, iss_rd, chk_a1, chk_a2, chk_rd;
  logic [31:0] wb_data, lu_data;
  logic lu_ready, iss_ready, hz1, hz2, hzd, stall_req, rf_we;
  logic [4:0] rf_a3;
  logic [31:0] rf_wd;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_rd(chk_rd),
    .hz1(hz1), .hz2(hz2), .hzd(hzd), .stall_req(stall_req),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending results in arrival order, busy bits, starvation bookkeeping.
  logic [36:0] exp_q[$];
  logic [31:0] m_busy;
  int          m_wait;
  bit          m_force;

  logic        last_we, last_stall, last_lr, last_ir, last_hzd;
  logic [4:0]  last_a3;
  logic [31:0] last_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    chk_a1 = 5'd0; chk_a2 = 5'd0; chk_rd = 5'd0;
  endtask

  // Called with inputs already set (at negedge); checks this cycle, then advances one clock.
  task automatic step();
    bit head_g, prim_g, byp_g, exp_lr, exp_ir;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    #1;
    last_we = rf_we; last_a3 = rf_a3; last_wd = rf_wd; last_stall = stall_req;
    last_lr = lu_ready; last_ir = iss_ready; last_hzd = hzd;
    if (reset) begin
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_lu_ready", 32'(lu_ready), 32'd0);
      check("rst_iss_ready", 32'(iss_ready), 32'd0);
      exp_q.delete();
      m_busy = '0; m_wait = 0; m_force = 1'b0;
    end else begin
      exp_lr = (exp_q.size() < DEPTH);
      exp_ir = !m_busy[iss_rd] || (iss_rd == 5'd0);
      head_g = 1'b0; prim_g = 1'b0; byp_g = 1'b0;
      exp_a3 = 5'd0; exp_wd = 32'd0;
      if (m_force) head_g = 1'b1;
      else if (wb_we && wb_rd != 5'd0) prim_g = 1'b1;
      else if (exp_q.size() > 0) head_g = 1'b1;
      else if (BYP && lu_valid && exp_lr && lu_rd != 5'd0) byp_g = 1'b1;
      if (head_g) begin exp_a3 = exp_q[0][36:32]; exp_wd = exp_q[0][31:0]; end
      else if (prim_g) begin exp_a3 = wb_rd; exp_wd = wb_data; end
      else if (byp_g) begin exp_a3 = lu_rd; exp_wd = lu_data; end
      check("rf_we", 32'(rf_we), 32'(head_g || prim_g || byp_g));
      if (head_g || prim_g || byp_g) begin
        check("rf_a3", 32'(rf_a3), 32'(exp_a3));
        check("rf_wd", rf_wd, exp_wd);
      end
      check("lu_ready", 32'(lu_ready), 32'(exp_lr));
      check("iss_ready", 32'(iss_ready), 32'(exp_ir));
      check("stall_req", 32'(stall_req), 32'(m_force));
      check("hz1", 32'(hz1), 32'(m_busy[chk_a1] && chk_a1 != 5'd0));
      check("hz2", 32'(hz2), 32'(m_busy[chk_a2] && chk_a2 != 5'd0));
      check("hzd", 32'(hzd), 32'(m_busy[chk_rd] && chk_rd != 5'd0));
      // Starvation bookkeeping: consecutive cycles the oldest result sat visible but unserved.
      if (head_g) begin
        m_wait = 0; m_force = 1'b0;
      end else if (exp_q.size() > 0) begin
        if (m_wait == STARVE_MAX - 1) begin m_force = 1'b1; m_wait = 0; end
        else m_wait++;
      end else m_wait = 0;
      if (head_g) begin
        m_busy[exp_q[0][36:32]] = 1'b0;
        void'(exp_q.pop_front());
      end
      if (byp_g) m_busy[lu_rd] = 1'b0;
      if (lu_valid && exp_lr && lu_rd != 5'd0 && !byp_g) exp_q.push_back({lu_rd, lu_data});
      if (iss_valid && exp_ir && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int force_at;

  initial begin
    idle_inputs();
    reset = 1'b1;
    exp_q.delete(); m_busy = '0; m_wait = 0; m_force = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Idle after reset
    idle_inputs(); step();
    check("idle_we", 32'(last_we), 32'd0);
    check("idle_lu_ready", 32'(last_lr), 32'd1);
    check("idle_iss_ready", 32'(last_ir), 32'd1);

    // Issue rd 5, then its result returns
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd5; chk_a1 = 5'd5; step();
    idle_inputs(); chk_a1 = 5'd5; step();
    check("hz1_after_issue", 32'(hz1), 32'd1);
    idle_inputs(); chk_a1 = 5'd5; lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEADBEEF; step();
    if (BYP) begin
      check("byp_we", 32'(last_we), 32'd1);
      check("byp_a3", 32'(last_a3), 32'd5);
    end
    idle_inputs(); chk_a1 = 5'd5; step();
    if (!BYP) begin
      check("lu_we", 32'(last_we), 32'd1);
      check("lu_a3", 32'(last_a3), 32'd5);
      check("lu_wd", last_wd, 32'hDEADBEEF);
    end
    idle_inputs(); chk_a1 = 5'd5; step();
    check("hz1_after_commit", 32'(hz1), 32'd0);

    // Starvation: primary writes every cycle, one queued result
    idle_inputs(); wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h77; step();
    force_at = -1;
    for (int i = 0; i < 8; i++) begin
      idle_inputs(); wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33; step();
      if (last_stall && force_at < 0) begin
        force_at = i;
        check("force_a3", 32'(last_a3), 32'd7);
      end else if (force_at >= 0 && i == force_at + 1) begin
        check("resume_a3", 32'(last_a3), 32'd3);
      end
    end
    check("force_cycle", 32'(force_at), 32'(STARVE_MAX));

    // Fill the FIFO behind a busy primary, then drain in order
    idle_inputs(); wb_we = 1'b1; wb_rd = 5'd4; lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h88; step();
    idle_inputs(); wb_we = 1'b1; wb_rd = 5'd4; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99; step();
    idle_inputs(); wb_we = 1'b1; wb_rd = 5'd4; lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hAA; step();
    check("full_lu_ready", 32'(last_lr), 32'd0);
    idle_inputs(); step();
    check("pop0_a3", 32'(last_a3), 32'd8);
    idle_inputs(); step();
    check("pop1_a3", 32'(last_a3), 32'd9);
    idle_inputs(); step();
    check("drained_we", 32'(last_we), 32'd0);

    // Busy destination blocks issue; x0 writes never reach the port
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd10; step();
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd10; step();
    check("busy_iss_ready", 32'(last_ir), 32'd0);
    idle_inputs(); lu_valid = 1'b1; lu_rd = 5'd0; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1; step();
    check("x0_no_we", 32'(last_we), 32'd0);
    idle_inputs(); step();
    check("x0_no_we_after", 32'(last_we), 32'd0);

    // Reset with queued entries and a busy register
    idle_inputs(); iss_valid = 1'b1; iss_rd = 5'd12; wb_we = 1'b1; wb_rd = 5'd2;
    lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'hD; step();
    idle_inputs(); wb_we = 1'b1; wb_rd = 5'd2; lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 32'hE;
    chk_rd = 5'd12; step();
    check("pre_rst_hzd", 32'(last_hzd), 32'd1);
    idle_inputs(); reset = 1'b1; step();
    check("rst_mid_we", 32'(last_we), 32'd0);
    idle_inputs(); chk_rd = 5'd12; step();
    check("post_rst_hzd", 32'(last_hzd), 32'd0);
    check("post_rst_we", 32'(last_we), 32'd0);
    check("post_rst_lu_ready", 32'(last_lr), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      reset     = ($urandom_range(0, 299) == 0);
      wb_we     = ($urandom_range(0, 9) < 6);
      wb_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data   = $urandom;
      lu_valid  = ($urandom_range(0, 9) < 4);
      lu_rd     = 5'($urandom_range(0, 15));
      lu_data   = $urandom;
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_rd    = 5'($urandom_range(0, 15));
      chk_a1    = 5'($urandom_range(0, 15));
      chk_a2    = 5'($urandom_range(0, 15));
      chk_rd    = 5'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
